// File: rtl/digital_mode_ctrl.sv
// digital_mode_ctrl: power sequencer for the DFE / ADC-TEG receiver back end.
// Brings up one path at a time (divider, settle, datapath, flush) and tears it
// down break-before-make (datapath off, drain, divider off) before switching.
// Every output is registered from the current sequencer state, so outputs
// follow a state change by one clock.
module digital_mode_ctrl #(
  parameter int DIV_SETTLE = 32,
  parameter int DFE_FLUSH  = 64,
  parameter int TEG_FLUSH  = 16,
  parameter int DRAIN      = 8,
  parameter int CW         = 8
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic       REQ_STB,
  input  logic [1:0] MODE_REQ,
  output logic       ENABLE_DIVIDER_DFE,
  output logic       ENABLE_DIVIDER_ADC_TEG,
  output logic       ENABLE_DFE,
  output logic       ENABLE_ADC_TEG,
  output logic       OUT_VALID,
  output logic [1:0] MODE_CUR,
  output logic       BUSY,
  output logic       ERR
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_DIV_ON   = 3'd1;
  localparam logic [2:0] S_PATH_ON  = 3'd2;
  localparam logic [2:0] S_RUN      = 3'd3;
  localparam logic [2:0] S_PATH_OFF = 3'd4;
  localparam logic [2:0] S_DIV_OFF  = 3'd5;

  localparam logic [1:0] M_NONE = 2'b00;
  localparam logic [1:0] M_DFE  = 2'b01;
  localparam logic [1:0] M_TEG  = 2'b10;
  localparam logic [1:0] M_RSVD = 2'b11;

  // A timed state lasting P cycles exits when the counter reads P-1.
  localparam logic [CW-1:0] SETTLE_LAST = CW'(DIV_SETTLE - 1);
  localparam logic [CW-1:0] DFE_LAST    = CW'(DFE_FLUSH - 1);
  localparam logic [CW-1:0] TEG_LAST    = CW'(TEG_FLUSH - 1);
  localparam logic [CW-1:0] DRAIN_LAST  = CW'(DRAIN - 1);

  logic [2:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    tgt, tgt_nxt;
  logic          pend_vld, pend_vld_nxt;
  logic [1:0]    pend_mode, pend_mode_nxt;

  logic          req_ok;
  logic          abort;
  logic          eff_vld;
  logic [1:0]    eff_mode;
  logic [CW-1:0] flush_last;
  logic          div_on;
  logic          path_on;

  // Request qualification and decode of the current state.
  always_comb begin
    req_ok     = REQ_STB && (MODE_REQ != M_RSVD);
    // Any non-reserved request that differs from the active target aborts.
    abort      = req_ok && (state != S_IDLE) && (MODE_REQ != tgt);
    // A strobe arriving on the DIV_OFF cycle overrides the stored request.
    eff_vld    = abort || pend_vld;
    eff_mode   = abort ? MODE_REQ : pend_mode;
    flush_last = (tgt == M_DFE) ? DFE_LAST : TEG_LAST;
    div_on     = state inside {S_DIV_ON, S_PATH_ON, S_RUN, S_PATH_OFF};
    path_on    = state inside {S_PATH_ON, S_RUN};
  end

  // Next-state, target and pending-request logic; aborts beat timer expiry.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_nxt     = state;
    tgt_nxt       = tgt;
    pend_vld_nxt  = abort ? 1'b1 : pend_vld;
    pend_mode_nxt = abort ? MODE_REQ : pend_mode;

    case (state)
      S_IDLE: begin
        if (req_ok && (MODE_REQ != M_NONE)) begin
          state_nxt = S_DIV_ON;
          tgt_nxt   = MODE_REQ;
        end
      end
      S_DIV_ON: begin
        if (abort)                     state_nxt = S_DIV_OFF;
        else if (cnt == SETTLE_LAST)   state_nxt = S_PATH_ON;
      end
      S_PATH_ON: begin
        if (abort)                     state_nxt = S_PATH_OFF;
        else if (cnt == flush_last)    state_nxt = S_RUN;
      end
      S_RUN: begin
        if (abort)                     state_nxt = S_PATH_OFF;
      end
      S_PATH_OFF: begin
        if (cnt == DRAIN_LAST)         state_nxt = S_DIV_OFF;
      end
      S_DIV_OFF: begin
        pend_vld_nxt  = 1'b0;
        pend_mode_nxt = M_NONE;
        if (eff_vld && (eff_mode != M_NONE)) begin
          state_nxt = S_DIV_ON;
          tgt_nxt   = eff_mode;
        end else begin
          state_nxt = S_IDLE;
          tgt_nxt   = M_NONE;
        end
      end
      default: begin
        state_nxt     = S_IDLE;
        tgt_nxt       = M_NONE;
        pend_vld_nxt  = 1'b0;
        pend_mode_nxt = M_NONE;
      end
    endcase

    // Counter restarts on every state entry and rests in the untimed states.
    if ((state_nxt != state) || (state_nxt == S_IDLE) || (state_nxt == S_RUN))
      cnt_nxt = '0;
    else
      cnt_nxt = cnt + CW'(1);
  end

  // Sequencer state registers.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (RES) begin
      state     <= S_IDLE;
      cnt       <= '0;
      tgt       <= M_NONE;
      pend_vld  <= 1'b0;
      pend_mode <= M_NONE;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      tgt       <= tgt_nxt;
      pend_vld  <= pend_vld_nxt;
      pend_mode <= pend_mode_nxt;
    end
  end

  // Registered outputs decoded from the current state; reset drops them at once.
  always_ff @(posedge CLK) begin
    if (RES) begin
      ENABLE_DIVIDER_DFE     <= 1'b0;
      ENABLE_DIVIDER_ADC_TEG <= 1'b0;
      ENABLE_DFE             <= 1'b0;
      ENABLE_ADC_TEG         <= 1'b0;
      OUT_VALID              <= 1'b0;
      MODE_CUR               <= M_NONE;
      BUSY                   <= 1'b0;
      ERR                    <= 1'b0;
    end else begin
      ENABLE_DIVIDER_DFE     <= div_on  && (tgt == M_DFE);
      ENABLE_DIVIDER_ADC_TEG <= div_on  && (tgt == M_TEG);
      ENABLE_DFE             <= path_on && (tgt == M_DFE);
      ENABLE_ADC_TEG         <= path_on && (tgt == M_TEG);
      OUT_VALID              <= (state == S_RUN);
      MODE_CUR               <= div_on ? tgt : M_NONE;
      BUSY                   <= !((state == S_IDLE) || (state == S_RUN)) || pend_vld;
      ERR                    <= REQ_STB && (MODE_REQ == M_RSVD);
    end
  end

endmodule

// File: tb/tb_digital_mode_ctrl.sv
// Testbench for digital_mode_ctrl: directed scenarios followed by random
// requests and resets, every cycle compared against a timeline model that
// tracks how long the active mode has been powering up or shutting down.
module tb_digital_mode_ctrl;

  localparam int SETTLE = 32;
  localparam int DFE_FL = 64;
  localparam int TEG_FL = 16;
  localparam int DRN    = 8;

  localparam logic [1:0] NONE = 2'b00;
  localparam logic [1:0] DFE  = 2'b01;
  localparam logic [1:0] TEG  = 2'b10;
  localparam logic [1:0] RSVD = 2'b11;

  typedef struct packed {
    logic       div_dfe;
    logic       div_teg;
    logic       en_dfe;
    logic       en_teg;
    logic       valid;
    logic [1:0] mode_cur;
    logic       busy;
    logic       err;
  } outs_t;

  logic       CLK = 1'b0;
  logic       RES;
  logic       REQ_STB;
  logic [1:0] MODE_REQ;
  logic       ENABLE_DIVIDER_DFE;
  logic       ENABLE_DIVIDER_ADC_TEG;
  logic       ENABLE_DFE;
  logic       ENABLE_ADC_TEG;
  logic       OUT_VALID;
  logic [1:0] MODE_CUR;
  logic       BUSY;
  logic       ERR;

  int total = 0;
  int bad   = 0;
  int ed    = -1;

  // Model: active mode (NONE when idle), direction, and cycles into that phase.
  logic [1:0] m_tgt  = NONE;
  bit         m_down = 1'b0;
  int         m_t    = 0;
  bit         m_pv   = 1'b0;
  logic [1:0] m_pm   = NONE;

  digital_mode_ctrl dut (
    .CLK                    (CLK),
    .RES                    (RES),
    .REQ_STB                (REQ_STB),
    .MODE_REQ               (MODE_REQ),
    .ENABLE_DIVIDER_DFE     (ENABLE_DIVIDER_DFE),
    .ENABLE_DIVIDER_ADC_TEG (ENABLE_DIVIDER_ADC_TEG),
    .ENABLE_DFE             (ENABLE_DFE),
    .ENABLE_ADC_TEG         (ENABLE_ADC_TEG),
    .OUT_VALID              (OUT_VALID),
    .MODE_CUR               (MODE_CUR),
    .BUSY                   (BUSY),
    .ERR                    (ERR)
  );

  always #5 CLK = ~CLK;

  function automatic int flush_of(input logic [1:0] m);
    return (m == DFE) ? DFE_FL : TEG_FL;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s at edge %0d: observed=%0h expected=%0h", tag, ed, obs, exp);
    end
  endtask

  // Expected outputs for one edge from the pre-edge model, then advance it.
  task automatic model_edge(input logic stb, input logic [1:0] mode, input logic res,
                            output outs_t e);
    logic req;
    logic abort;
    e = '0;
    if (res) begin
      m_tgt = NONE; m_down = 1'b0; m_t = 0; m_pv = 1'b0; m_pm = NONE;
    end else begin
      if (m_tgt != NONE) begin
        if (!m_down) begin
          e.div_dfe  = (m_tgt == DFE);
          e.div_teg  = (m_tgt == TEG);
          e.en_dfe   = (m_tgt == DFE) && (m_t >= SETTLE);
          e.en_teg   = (m_tgt == TEG) && (m_t >= SETTLE);
          e.valid    = (m_t >= SETTLE + flush_of(m_tgt));
          e.mode_cur = m_tgt;
          e.busy     = !e.valid || m_pv;
        end else begin
          e.busy = 1'b1;
          if (m_t < DRN) begin
            e.div_dfe  = (m_tgt == DFE);
            e.div_teg  = (m_tgt == TEG);
            e.mode_cur = m_tgt;
          end
        end
      end
      e.err = stb && (mode == RSVD);

      req = stb && (mode != RSVD);
      if (m_tgt == NONE) begin
        if (req && (mode != NONE)) begin
          m_tgt = mode; m_down = 1'b0; m_t = 0;
        end
      end else begin
        abort = req && (mode != m_tgt);
        if (abort) begin
          m_pv = 1'b1; m_pm = mode;
        end
        if (!m_down) begin
          if (abort) begin
            // Still only the divider on: skip the drain, go to divider-off.
            m_down = 1'b1;
            m_t    = (m_t < SETTLE) ? DRN : 0;
          end else if (m_t < SETTLE + flush_of(m_tgt)) begin
            m_t++;
          end
        end else if (m_t < DRN) begin
          m_t++;
        end else begin
          if (m_pv && (m_pm != NONE)) begin
            m_tgt = m_pm; m_down = 1'b0; m_t = 0;
          end else begin
            m_tgt = NONE;
          end
          m_pv = 1'b0; m_pm = NONE;
        end
      end
    end
  endtask

  // One clock edge with the given inputs, checked against the model.
  task automatic cyc(input logic stb, input logic [1:0] mode, input logic res);
    outs_t e;
    outs_t o;
    REQ_STB  = stb;
    MODE_REQ = mode;
    RES      = res;
    ed++;
    @(posedge CLK);
    model_edge(stb, mode, res, e);
    #1;
    o = {ENABLE_DIVIDER_DFE, ENABLE_DIVIDER_ADC_TEG, ENABLE_DFE, ENABLE_ADC_TEG,
         OUT_VALID, MODE_CUR, BUSY, ERR};
    check("outputs", 32'(o), 32'(e));
    check("one_divider", 32'(ENABLE_DIVIDER_DFE & ENABLE_DIVIDER_ADC_TEG), 32'd0);
  endtask

  task automatic idle_to(input int n);
    while (ed < n) cyc(1'b0, NONE, 1'b0);
  endtask

  initial begin
    // Reset
    cyc(1'b0, NONE, 1'b1);
    cyc(1'b0, NONE, 1'b1);
    check("reset_outputs", 32'({ENABLE_DIVIDER_DFE, ENABLE_DIVIDER_ADC_TEG, ENABLE_DFE,
                                ENABLE_ADC_TEG, OUT_VALID, MODE_CUR, BUSY, ERR}), 32'd0);
    cyc(1'b0, NONE, 1'b0);

    // DFE start-up, with a repeated DFE request during PATH_ON
    ed = -1;
    cyc(1'b1, DFE, 1'b0);
    check("t1_div_e0", 32'(ENABLE_DIVIDER_DFE), 32'd0);
    idle_to(1);
    check("t1_div_e1", 32'(ENABLE_DIVIDER_DFE), 32'd1);
    check("t1_mode_e1", 32'(MODE_CUR), 32'd1);
    idle_to(32);
    check("t1_en_e32", 32'(ENABLE_DFE), 32'd0);
    idle_to(33);
    check("t1_en_e33", 32'(ENABLE_DFE), 32'd1);
    idle_to(39);
    cyc(1'b1, DFE, 1'b0);
    idle_to(96);
    check("t1_valid_e96", 32'(OUT_VALID), 32'd0);
    check("t1_busy_e96", 32'(BUSY), 32'd1);
    idle_to(97);
    check("t1_valid_e97", 32'(OUT_VALID), 32'd1);
    check("t1_busy_e97", 32'(BUSY), 32'd0);
    idle_to(100);

    // Switch DFE RUN -> ADC_TEG
    ed = -1;
    cyc(1'b1, TEG, 1'b0);
    idle_to(1);
    check("t2_en_dfe_e1", 32'(ENABLE_DFE), 32'd0);
    check("t2_valid_e1", 32'(OUT_VALID), 32'd0);
    idle_to(8);
    check("t2_div_dfe_e8", 32'(ENABLE_DIVIDER_DFE), 32'd1);
    idle_to(9);
    check("t2_div_dfe_e9", 32'(ENABLE_DIVIDER_DFE), 32'd0);
    check("t2_div_teg_e9", 32'(ENABLE_DIVIDER_ADC_TEG), 32'd0);
    idle_to(10);
    check("t2_div_teg_e10", 32'(ENABLE_DIVIDER_ADC_TEG), 32'd1);
    idle_to(41);
    check("t2_en_teg_e41", 32'(ENABLE_ADC_TEG), 32'd0);
    idle_to(42);
    check("t2_en_teg_e42", 32'(ENABLE_ADC_TEG), 32'd1);
    idle_to(57);
    check("t2_valid_e57", 32'(OUT_VALID), 32'd0);
    idle_to(58);
    check("t2_valid_e58", 32'(OUT_VALID), 32'd1);
    idle_to(60);

    // Reserved request in RUN
    ed = -1;
    cyc(1'b1, RSVD, 1'b0);
    check("t4_err_e0", 32'(ERR), 32'd1);
    check("t4_valid_e0", 32'(OUT_VALID), 32'd1);
    idle_to(1);
    check("t4_err_e1", 32'(ERR), 32'd0);
    check("t4_en_teg_e1", 32'(ENABLE_ADC_TEG), 32'd1);
    check("t4_valid_e1", 32'(OUT_VALID), 32'd1);
    idle_to(3);

    // Shut down to idle
    ed = -1;
    cyc(1'b1, NONE, 1'b0);
    idle_to(10);
    check("t6_idle_mode", 32'(MODE_CUR), 32'd0);
    check("t6_idle_busy", 32'(BUSY), 32'd0);

    // Abort during DIV_ON; latest request (idle) wins
    ed = -1;
    cyc(1'b1, DFE, 1'b0);
    idle_to(4);
    cyc(1'b1, TEG, 1'b0);
    cyc(1'b1, NONE, 1'b0);
    check("t3_div_dfe_e6", 32'(ENABLE_DIVIDER_DFE), 32'd0);
    check("t3_div_teg_e6", 32'(ENABLE_DIVIDER_ADC_TEG), 32'd0);
    idle_to(7);
    check("t3_mode_e7", 32'(MODE_CUR), 32'd0);
    check("t3_busy_e7", 32'(BUSY), 32'd0);
    idle_to(12);
    check("t3_div_teg_e12", 32'(ENABLE_DIVIDER_ADC_TEG), 32'd0);

    // Reset mid-sequence, strobe coincident with reset ignored
    ed = -1;
    cyc(1'b1, DFE, 1'b0);
    idle_to(49);
    check("t5_en_dfe_e49", 32'(ENABLE_DFE), 32'd1);
    cyc(1'b1, TEG, 1'b1);
    check("t5_all_zero_e50", 32'({ENABLE_DIVIDER_DFE, ENABLE_DIVIDER_ADC_TEG, ENABLE_DFE,
                                  ENABLE_ADC_TEG, OUT_VALID, MODE_CUR, BUSY, ERR}), 32'd0);
    idle_to(51);
    check("t5_div_teg_e51", 32'(ENABLE_DIVIDER_ADC_TEG), 32'd0);
    cyc(1'b1, TEG, 1'b0);
    idle_to(53);
    check("t5_div_teg_e53", 32'(ENABLE_DIVIDER_ADC_TEG), 32'd1);
    check("t5_div_dfe_e53", 32'(ENABLE_DIVIDER_DFE), 32'd0);

    // Random requests and occasional resets against the model
    for (int i = 0; i < 6000; i++) begin
      int         rate;
      logic       stb;
      logic [1:0] mode;
      logic       res;
      rate = (i < 3000) ? 4 : 1;
      stb  = ($urandom_range(0, 99) < rate);
      mode = 2'($urandom_range(0, 3));
      res  = ($urandom_range(0, 1499) == 0);
      cyc(stb, mode, res);
    end
    for (int i = 0; i < 200; i++) cyc(1'b0, NONE, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
